mult_div: RTL and testbench

MULT_DIV -- requirements
Module: mult_div

---
 rtl/mult_div.sv | 222 ++++++++++++++++++++++
 tb/tb_mult_div.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div.sv
// ----------------------------------------------------------------------------
// mult_div -- iterative 32x32 multiply / divide unit with HI/LO registers.
//
// One bit of the operation is processed per clock. A started operation takes
// 33 cycles from the start edge to the edge that writes hi/lo:
//   - 1 capture edge in IDLE
//   - 32 iteration edges in CALC
//   - 1 sign-fix / write edge in FIX
// done then pulses for one cycle.
//
// Ports
//   clk       in   1   rising-edge clock
//   rst       in   1   asynchronous, active-high reset
//   start     in   1   request a new operation (accepted only in IDLE)
//   op        in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a     in  32   multiplicand / dividend; also MTHI/MTLO write data
//   src_b     in  32   multiplier / divisor
//   hi_write  in   1   MTHI: load hi from src_a (IDLE, no start)
//   lo_write  in   1   MTLO: load lo from src_a (IDLE, no start)
//   busy      out  1   operation in progress (state != IDLE)
//   done      out  1   one-cycle pulse after hi/lo received a result
//   hi        out 32   product upper word / remainder
//   lo        out 32   product lower word / quotient
//
// Handshake: a start seen high on a rising edge while busy is low is
// accepted on that edge. A start seen while busy is high is dropped. There
// is no backpressure on the result; done marks the first cycle in which
// hi/lo hold it. The done cycle is already IDLE, so a back-to-back start
// may be presented in that same cycle.
//
// The FSM state is the internal signal 'state'. It is reachable
// hierarchically (dut.state) for debug.
// ----------------------------------------------------------------------------
module mult_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_write,
  input  logic        lo_write,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // Captured operation context
  logic [1:0]  op_r;       // op[1]: divide, op[0]: unsigned
  logic [31:0] b_r;        // |src_b|: multiplicand or divisor
  logic [31:0] a_orig;     // raw src_a, returned as hi on divide by zero
  logic        neg_res;    // negate product / quotient
  logic        neg_rem;    // negate remainder (dividend was negative)
  logic        div_zero;   // divisor was zero
  logic [5:0]  cnt;        // iteration counter, 0..32

  // Shared 64-bit working register.
  //   multiply: upper half is the partial product; lower half is the
  //             multiplier, shifted out LSB first.
  //   divide:   upper half is the partial remainder; lower half is the
  //             dividend, shifted out MSB first while quotient bits shift
  //             in at the bottom.
  logic [63:0] acc;

  // ---------------------------------------------------------------------
  // Operand conditioning at capture time
  // ---------------------------------------------------------------------
  logic        in_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  always_comb begin
    in_signed = ~op[0];
    abs_a     = (in_signed && src_a[31]) ? (32'd0 - src_a) : src_a;
    abs_b     = (in_signed && src_b[31]) ? (32'd0 - src_b) : src_b;
  end

  // ---------------------------------------------------------------------
  // One multiply step: conditional add of the multiplicand, then shift
  // right. The 33-bit sum keeps the carry, which becomes the new MSB.
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, b_r} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
  end

  // ---------------------------------------------------------------------
  // One restoring divide step. Shift the {rem, dividend} pair left by one
  // bit, then trial-subtract the divisor from the 33-bit top part.
  //
  // The shifted remainder is below 2*divisor, so a non-negative difference
  // always fits in 32 bits. Bit 32 of the difference is therefore a clean
  // borrow flag: when it is set, the shifted value is kept (restore).
  // ---------------------------------------------------------------------
  logic [64:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    div_shift = {acc, 1'b0};
    div_diff  = div_shift[64:32] - {1'b0, b_r};
    if (div_diff[32]) begin
      div_next = div_shift[63:0];
    end else begin
      div_next = {div_diff[31:0], div_shift[31:1], 1'b1};
    end
  end

  // ---------------------------------------------------------------------
  // Sign correction and result selection in FIX
  // ---------------------------------------------------------------------
  logic [63:0] prod;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod = neg_res ? (64'd0 - acc) : acc;
    quo  = neg_res ? (32'd0 - acc[31:0]) : acc[31:0];
    rem  = neg_rem ? (32'd0 - acc[63:32]) : acc[63:32];
    if (!op_r[1]) begin
      fix_hi = prod[63:32];
      fix_lo = prod[31:0];
    end else if (div_zero) begin
      // Divide by zero: all-ones quotient. The dividend is returned
      // unmodified, with no sign handling.
      fix_hi = a_orig;
      fix_lo = 32'hFFFF_FFFF;
    end else begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      // cnt still holds 31 during the 32nd iteration
      CALC:    if (cnt == 6'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------
  // Datapath and architectural registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r     <= 2'd0;
      b_r      <= 32'd0;
      a_orig   <= 32'd0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= 6'd0;
      acc      <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // start wins over any simultaneous MTHI/MTLO
            op_r     <= op;
            b_r      <= abs_b;
            a_orig   <= src_a;
            acc      <= {32'd0, abs_a};
            neg_res  <= in_signed & (src_a[31] ^ src_b[31]);
            neg_rem  <= in_signed & src_a[31];
            div_zero <= (src_b == 32'd0);
            cnt      <= 6'd0;
          end else begin
            if (hi_write) hi <= src_a;
            if (lo_write) lo <= src_a;
          end
        end
        CALC: begin
          acc <= op_r[1] ? div_next : mul_next;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// ----------------------------------------------------------------------------
// tb_mult_div -- self-checking bench for mult_div.
//
// Structure:
//   - a clock/reset block
//   - driver tasks (drive_start, wait_done)
//   - one task per scenario, each with inline comparisons
//   - a final summary report
//
// Expected results come from ref_model. It uses plain 64-bit arithmetic
// (multiplication, / and %) together with the divide-by-zero rule.
//
// Timing: inputs are driven and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mult_div;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        hi_write;
  logic        lo_write;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entries are {hi, lo}
  logic [63:0] exp_q[$];

  mult_div dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .hi_write (hi_write),
    .lo_write (lo_write),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  // --------------------------------------------------------------------------
  // Clock and watchdog
  // --------------------------------------------------------------------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  function automatic void ref_model(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] h, output logic [31:0] l);
    longint      sa;
    longint      sb;
    logic [63:0] r64;
    logic [63:0] q64;
    logic [63:0] ua;
    logic [63:0] ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h  = 32'd0;
    l  = 32'd0;
    case (o)
      OP_MULT: begin
        r64 = sa * sb;
        h = r64[63:32];
        l = r64[31:0];
      end
      OP_MULTU: begin
        r64 = ua * ub;
        h = r64[63:32];
        l = r64[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          h = a;
          l = 32'hFFFF_FFFF;
        end else if (o == OP_DIV) begin
          q64 = sa / sb;
          r64 = sa % sb;
          h = r64[31:0];
          l = q64[31:0];
        end else begin
          q64 = ua / ub;
          r64 = ua % ub;
          h = r64[31:0];
          l = q64[31:0];
        end
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(1, 15));
      4:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------

  // Called on a falling edge. Returns on the falling edge after the capture
  // edge, with start and the write strobes already released.
  task automatic drive_start(input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic hw, input logic lw);
    start    = 1'b1;
    op       = o;
    src_a    = a;
    src_b    = b;
    hi_write = hw;
    lo_write = lw;
    @(negedge clk);
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
  endtask

  // Waits, within a bounded number of cycles, for the falling edge on which
  // done is high. cyc counts cycles after the falling edge following the
  // capture edge, so the expected latency value is 33 (-1 on timeout).
  // busy_ok is cleared if busy drops early or is still high alongside done.
  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc     = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 60) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (!done) cyc = -1;
    else if (busy) busy_ok = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    src_a    = 32'd0;
    src_b    = 32'd0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
    end
    n_checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [1:0]  t_op [8];
    logic [31:0] t_a  [8];
    logic [31:0] t_b  [8];
    logic [31:0] t_hi [8];
    logic [31:0] t_lo [8];
    int          cyc;
    bit          bok;
    t_op[0] = OP_MULT;  t_a[0] = 32'hFFFF_FFFD; t_b[0] = 32'd7;
    t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFEB;
    t_op[1] = OP_MULTU; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'hFFFF_FFFF;
    t_hi[1] = 32'hFFFF_FFFE; t_lo[1] = 32'h0000_0001;
    t_op[2] = OP_DIV;   t_a[2] = 32'hFFFF_FFF9; t_b[2] = 32'd2;
    t_hi[2] = 32'hFFFF_FFFF; t_lo[2] = 32'hFFFF_FFFD;
    t_op[3] = OP_DIVU;  t_a[3] = 32'd100;       t_b[3] = 32'd0;
    t_hi[3] = 32'h0000_0064; t_lo[3] = 32'hFFFF_FFFF;
    t_op[4] = OP_DIV;   t_a[4] = 32'h8000_0000; t_b[4] = 32'hFFFF_FFFF;
    t_hi[4] = 32'h0000_0000; t_lo[4] = 32'h8000_0000;
    t_op[5] = OP_DIV;   t_a[5] = 32'd7;         t_b[5] = 32'hFFFF_FFFE;
    t_hi[5] = 32'h0000_0001; t_lo[5] = 32'hFFFF_FFFD;
    t_op[6] = OP_DIV;   t_a[6] = 32'hFFFF_FFF9; t_b[6] = 32'd0;
    t_hi[6] = 32'hFFFF_FFF9; t_lo[6] = 32'hFFFF_FFFF;
    t_op[7] = OP_MULT;  t_a[7] = 32'h8000_0000; t_b[7] = 32'h8000_0000;
    t_hi[7] = 32'h4000_0000; t_lo[7] = 32'h0000_0000;
    for (int i = 0; i < 8; i++) begin
      drive_start(t_op[i], t_a[i], t_b[i], 1'b0, 1'b0);
      wait_done(cyc, bok);
      n_checks++;
      if (cyc !== 33) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d required 33", i, cyc);
      end
      n_checks++;
      if (!bok) begin
        n_fail++;
        $display("FAIL vec%0d_busy: busy=%b during run/at done, required 1 then 0", i, busy);
      end
      n_checks++;
      if (hi !== t_hi[i] || lo !== t_lo[i]) begin
        n_fail++;
        $display("FAIL vec%0d_result: hi=%h lo=%h required hi=%h lo=%h",
                 i, hi, lo, t_hi[i], t_lo[i]);
      end
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_done_pulse: done=%b one cycle later, required 0", i, done);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
    bit          bok;
    for (int i = 0; i < 30; i++) begin
      o = 2'($urandom_range(0, 3));
      a = pick_operand();
      b = pick_operand();
      ref_model(o, a, b, eh, el);
      drive_start(o, a, b, 1'b0, 1'b0);
      wait_done(cyc, bok);
      n_checks++;
      if (cyc !== 33 || !bok) begin
        n_fail++;
        $display("FAIL rnd%0d_timing: latency=%0d busy_ok=%0d required 33/1", i, cyc, bok);
      end
      n_checks++;
      if (hi !== eh || lo !== el) begin
        n_fail++;
        $display("FAIL rnd%0d_result: op=%0d a=%h b=%h hi=%h lo=%h required hi=%h lo=%h",
                 i, o, a, b, hi, lo, eh, el);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    logic [63:0] exp_v;
    int          cyc;
    bit          bok;
    o = 2'($urandom_range(0, 3));
    a = pick_operand();
    b = pick_operand();
    ref_model(o, a, b, eh, el);
    exp_q.push_back({eh, el});
    drive_start(o, a, b, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      wait_done(cyc, bok);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (cyc !== 33) begin
        n_fail++;
        $display("FAIL b2b%0d_latency: got %0d required 33", i, cyc);
      end
      n_checks++;
      if ({hi, lo} !== exp_v) begin
        n_fail++;
        $display("FAIL b2b%0d_result: hi=%h lo=%h required hi=%h lo=%h",
                 i, hi, lo, exp_v[63:32], exp_v[31:0]);
      end
      if (i < 5) begin
        // Start in the done cycle itself
        o = 2'($urandom_range(0, 3));
        a = pick_operand();
        b = pick_operand();
        ref_model(o, a, b, eh, el);
        exp_q.push_back({eh, el});
        drive_start(o, a, b, 1'b0, 1'b0);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_queue: %0d entries left required 0", exp_q.size());
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    int cyc;
    bit bok;
    // Known hi/lo before the run
    hi_write = 1'b1;
    lo_write = 1'b1;
    src_a    = 32'h1111_2222;
    @(negedge clk);
    hi_write = 1'b0;
    lo_write = 1'b0;
    drive_start(OP_DIVU, 32'd9, 32'd4, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    start    = 1'b1;
    op       = OP_MULT;
    src_a    = 32'h0000_DEAD;
    src_b    = 32'd3;
    hi_write = 1'b1;
    lo_write = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    hi_write = 1'b0;
    lo_write = 1'b0;
    n_checks++;
    if (hi !== 32'h1111_2222 || lo !== 32'h1111_2222 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_write_ignored: hi=%h lo=%h busy=%b required 11112222/11112222/1",
               hi, lo, busy);
    end
    wait_done(cyc, bok);
    n_checks++;
    if (cyc !== 28) begin
      n_fail++;
      $display("FAIL busy_start_latency: got %0d required 28", cyc);
    end
    n_checks++;
    if (hi !== 32'd1 || lo !== 32'd2) begin
      n_fail++;
      $display("FAIL busy_start_result: hi=%h lo=%h required 1/2", hi, lo);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_no_ghost_op: busy=%b required 0", busy);
    end
  endtask

  task automatic test_hilo_write();
    int cyc;
    bit bok;
    hi_write = 1'b1;
    lo_write = 1'b1;
    src_a    = 32'hA5A5_A5A5;
    @(negedge clk);
    hi_write = 1'b0;
    lo_write = 1'b0;
    n_checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL both_write: hi=%h lo=%h required a5a5a5a5/a5a5a5a5", hi, lo);
    end
    lo_write = 1'b1;
    src_a    = 32'h0000_1234;
    @(negedge clk);
    lo_write = 1'b0;
    n_checks++;
    if (hi !== 32'hA5A5_A5A5 || lo !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL mtlo: hi=%h lo=%h required a5a5a5a5/00001234", hi, lo);
    end
    drive_start(OP_MULTU, 32'd7, 32'd3, 1'b1, 1'b0);
    n_checks++;
    if (hi !== 32'hA5A5_A5A5 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_beats_mthi: hi=%h busy=%b required a5a5a5a5/1", hi, busy);
    end
    wait_done(cyc, bok);
    n_checks++;
    if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd21) begin
      n_fail++;
      $display("FAIL start_beats_mthi_result: latency=%0d hi=%h lo=%h required 33/0/21",
               cyc, hi, lo);
    end
    hi_write = 1'b1;
    src_a    = 32'h0000_CAFE;
    @(negedge clk);
    hi_write = 1'b0;
    n_checks++;
    if (hi !== 32'h0000_CAFE || lo !== 32'd21) begin
      n_fail++;
      $display("FAIL mthi: hi=%h lo=%h required 0000cafe/00000015", hi, lo);
    end
  endtask

  task automatic test_abort();
    int cyc;
    bit bok;
    bit saw_done;
    drive_start(OP_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_reset: busy=%b done=%b hi=%h lo=%h required 0/0/0/0",
               busy, done, hi, lo);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: saw_done=%0d busy=%b required 0/0", saw_done, busy);
    end
    drive_start(OP_MULTU, 32'd5, 32'd6, 1'b0, 1'b0);
    wait_done(cyc, bok);
    n_checks++;
    if (cyc !== 33 || hi !== 32'd0 || lo !== 32'd30) begin
      n_fail++;
      $display("FAIL abort_restart: latency=%0d hi=%h lo=%h required 33/0/30", cyc, hi, lo);
    end
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Sequence and report
  // --------------------------------------------------------------------------
  initial begin
    test_reset();
    test_vectors();
    test_hilo_write();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    test_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
